grf_hazard_scoreboard: RTL and testbench
========================================

# grf_hazard_scoreboard

Stall controller for the 5-stage pipeline's general register file. Keeps a per-register countdown of cycles until each in-flight result becomes forwardable, and compares it with the consumer's use deadline for the instruction in D. Raises `stall` to freeze F/D and insert a bubble into E. Also stalls multiply/divide instructions while the MDU is busy, and counts stall cycles for performance reporting.

## Interface
Parameters:
- `CNT_W`, 3 — countdown width; legal Tnew range is 0..2^CNT_W−1.
- `PERF_W`, 32 — stall-cycle counter width.

Ports:
- `clk`  in  1  — the single clock.
- `reset`  in  1  — synchronous, active-high.
- `issue_valid`  in  1  — a real (non-bubble) instruction sits in D.
- `issue_rs`  in  5  — rs address of the D instruction.
- `issue_rt`  in  5  — rt address of the D instruction.
- `issue_use_rs`  in  1  — the D instruction reads rs.
- `issue_use_rt`  in  1  — the D instruction reads rt.
- `issue_tuse_rs`  in  2  — cycles from D until the rs value is consumed.
- `issue_tuse_rt`  in  2  — cycles from D until the rt value is consumed.
- `issue_wr`  in  1  — the D instruction writes the GRF.
- `issue_dst`  in  5  — GRF destination address.
- `issue_tnew`  in  CNT_W  — cycles from leaving D until the result is forwardable.
- `issue_is_md`  in  1  — the D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- `mdu_busy`  in  1  — MDU start pulse or busy flag, taken from E.
- `stall`  out  1  — freeze PC and F/D, bubble E.
- `busy_mask`  out  32  — bit r set when cnt[r] ≠ 0.
- `stall_count`  out  PERF_W  — cumulative number of stall cycles.

## Operation
- State: `cnt[0..31]`, each CNT_W wide. `cnt[0]` is hard-wired to 0 and never written.
- Hazard terms, computed from the registered `cnt` only:
  - `h_rs = issue_use_rs && issue_rs≠0 && cnt[issue_rs] > issue_tuse_rs`
  - `h_rt` is the same expression for rt.
  - `h_md = issue_is_md && mdu_busy`
- `stall = issue_valid && !reset && (h_rs || h_rt || h_md)`. The output is purely combinational from the inputs and the registered state.
- An instruction is accepted when `issue_valid && !stall`.
- Per-cycle counter update, at the posedge:
  1. Every `cnt[r]` that is non-zero decrements by 1. Counters saturate at 0.
  2. If the instruction is accepted with `issue_wr && issue_dst≠0`, `cnt[issue_dst]` loads `issue_tnew`. This load overrides step 1 for that register, because the younger writer wins.
- No accept (stall, or `issue_valid` low) means decrement only. A bubble in E never writes the scoreboard.
- `issue_tnew = 0` loads 0. The register counts as ready immediately, e.g. for `lui` forwarded from E.
- Self-dependency (the D instruction reads and writes the same register) is checked against the pre-update `cnt`. The new load does not stall its own producer.
- `stall_count` increments by 1 every cycle `stall` is high. It wraps at 2^PERF_W.
- `busy_mask[r] = (cnt[r] ≠ 0)`. `busy_mask[0]` is always 0.

## Timing
- Reset, sampled at posedge with `reset` high:
  - all `cnt` go to 0 and `stall_count` goes to 0.
  - `stall` is 0 throughout any cycle in which `reset` is high.
  - `busy_mask` reads 0 from the cycle after the reset edge.
- Reset mid-operation discards all pending entries. Any hazard is forgotten, and the pipeline is reset in the same cycle.
- Stall latency is zero: a hazard asserts `stall` in the same cycle the consumer is in D.
- A producer with Tnew = t accepted at edge k holds `cnt = t` after edge k, and t−j after edge k+j.
- A consumer with Tuse = u stalls while `cnt > u`. It stalls exactly max(0, cnt−u) cycles.
- Simultaneous events on one register in one cycle (decrement plus new load): the load wins.
- Stall and MDU: `mdu_busy` is sampled combinationally. `stall` releases in the first cycle `mdu_busy` is low.

## Test plan
- Reset then idle: hold `reset` for 2 cycles with random issue inputs → `stall`=0 in those cycles, `busy_mask`=0, `stall_count`=0.
- Load-use: lw writing $8 (Tnew=3) accepted, then the next instruction reads rs=$8 with Tuse=0 → `stall` high for exactly 2 cycles, released in the 3rd, `stall_count`=2.
- ALU producer: add writing $9 (Tnew=1), then beq reading $9 (Tuse=0) → 0 stall cycles (1 > 0 fails on the next cycle, since cnt has already decremented to 0 when the consumer is in D).
- $0 and tnew=0: lw to $0 (Tnew=3) then a read of $0, plus lui to $5 (Tnew=0) then a read of $5 → `stall` never asserts, and `busy_mask` bits 0 and 5 stay 0.
- Write-after-write: lw $4 (Tnew=3), then add $4 (Tnew=1), then a read of $4 (Tuse=0) → `cnt[4]`=1 after the second accept, and the third instruction does not stall.
- MDU and reset: hold `mdu_busy` high for 5 cycles with `issue_is_md`=1 → `stall` high for 5 cycles. Assert `reset` during the 3rd cycle → `stall`=0 in that cycle, and `stall_count`=0 after the reset edge.

Source files
------------

// File: rtl/grf_hazard_scoreboard_if.sv
// Issue-side bundle between the decode stage and the GRF hazard scoreboard.
// The pipeline (master) presents the D instruction; the scoreboard (slave) answers with stall.
interface grf_hazard_scoreboard_if #(
    parameter int CNT_W  = 3,
    parameter int PERF_W = 32
);
    logic              issue_valid;
    logic [4:0]        issue_rs;
    logic [4:0]        issue_rt;
    logic              issue_use_rs;
    logic              issue_use_rt;
    logic [1:0]        issue_tuse_rs;
    logic [1:0]        issue_tuse_rt;
    logic              issue_wr;
    logic [4:0]        issue_dst;
    logic [CNT_W-1:0]  issue_tnew;
    logic              issue_is_md;
    logic              mdu_busy;
    logic              stall;
    logic [31:0]       busy_mask;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
        output issue_tuse_rs, issue_tuse_rt, issue_wr, issue_dst, issue_tnew,
        output issue_is_md, mdu_busy,
        input  stall, busy_mask, stall_count
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
        input  issue_tuse_rs, issue_tuse_rt, issue_wr, issue_dst, issue_tnew,
        input  issue_is_md, mdu_busy,
        output stall, busy_mask, stall_count
    );
endinterface

// File: rtl/grf_hazard_scoreboard.sv
// GRF hazard scoreboard: per-register Tnew countdowns compared against the D-stage Tuse,
// plus MDU-busy stalling and a stall-cycle performance counter.
module grf_hazard_scoreboard #(
    parameter int CNT_W  = 3,
    parameter int PERF_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    grf_hazard_scoreboard_if.slave sb
);
    // Comparison width covers both the countdown and the 2-bit Tuse.
    localparam int CMP_W = (CNT_W > 2) ? CNT_W : 2;

    logic [CNT_W-1:0]  cnt_q [32];
    logic [CNT_W-1:0]  cnt_d [32];
    logic [PERF_W-1:0] stall_count_q;
    logic [PERF_W-1:0] stall_count_d;

    logic [CMP_W-1:0]  rs_cnt;
    logic [CMP_W-1:0]  rt_cnt;
    logic [CMP_W-1:0]  rs_tuse;
    logic [CMP_W-1:0]  rt_tuse;
    logic              h_rs;
    logic              h_rt;
    logic              h_md;
    logic              stall;
    logic              load_en;

    // Hazards look only at the registered counts, so a self-dependent producer never stalls itself.
    always_comb begin
        rs_cnt        = CMP_W'(cnt_q[sb.issue_rs]);
        rt_cnt        = CMP_W'(cnt_q[sb.issue_rt]);
        rs_tuse       = CMP_W'(sb.issue_tuse_rs);
        rt_tuse       = CMP_W'(sb.issue_tuse_rt);
        h_rs          = sb.issue_use_rs && (sb.issue_rs != 5'd0) && (rs_cnt > rs_tuse);
        h_rt          = sb.issue_use_rt && (sb.issue_rt != 5'd0) && (rt_cnt > rt_tuse);
        h_md          = sb.issue_is_md && sb.mdu_busy;
        stall         = sb.issue_valid && !reset && (h_rs || h_rt || h_md);
        load_en       = sb.issue_valid && !stall && sb.issue_wr && (sb.issue_dst != 5'd0);
        stall_count_d = stall_count_q + {{(PERF_W-1){1'b0}}, stall};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt_d[gi]        = '0;
                assign sb.busy_mask[gi] = 1'b0;
            end else begin : g_reg
                // A fresh load from the younger writer overrides the countdown.
                assign cnt_d[gi] = (load_en && (sb.issue_dst == 5'(gi))) ? sb.issue_tnew :
                                   ((cnt_q[gi] != '0) ? cnt_q[gi] - 1'b1 : '0);
                assign sb.busy_mask[gi] = (cnt_q[gi] != '0);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign sb.stall       = stall;
    assign sb.stall_count = stall_count_q;
endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Scenario bench for grf_hazard_scoreboard: directed hazard cases plus a randomized run
// against a small behavioural model, with expected results queued at drive time.
module tb_grf_hazard_scoreboard;
    localparam int CNT_W  = 3;
    localparam int PERF_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grf_hazard_scoreboard_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

    grf_hazard_scoreboard #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (bus)
    );

    typedef struct {
        logic              stall;
        logic [31:0]       mask;
        logic [PERF_W-1:0] count;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic idle();
        bus.issue_valid   = 1'b0;
        bus.issue_rs      = 5'd0;
        bus.issue_rt      = 5'd0;
        bus.issue_use_rs  = 1'b0;
        bus.issue_use_rt  = 1'b0;
        bus.issue_tuse_rs = 2'd0;
        bus.issue_tuse_rt = 2'd0;
        bus.issue_wr      = 1'b0;
        bus.issue_dst     = 5'd0;
        bus.issue_tnew    = '0;
        bus.issue_is_md   = 1'b0;
        bus.mdu_busy      = 1'b0;
    endtask

    task automatic drive(input logic valid, input logic [4:0] rs, input logic use_rs,
                         input logic [1:0] tuse_rs, input logic wr, input logic [4:0] dst,
                         input logic [CNT_W-1:0] tnew);
        idle();
        bus.issue_valid   = valid;
        bus.issue_rs      = rs;
        bus.issue_use_rs  = use_rs;
        bus.issue_tuse_rs = tuse_rs;
        bus.issue_wr      = wr;
        bus.issue_dst     = dst;
        bus.issue_tnew    = tnew;
    endtask

    task automatic push_stall(input logic s);
        exp_t e;
        e.stall = s;
        e.mask  = '0;
        e.count = '0;
        expq.push_back(e);
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        to_drive();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.issue_valid   = 1'b1;
            bus.issue_rs      = 5'($urandom_range(1, 31));
            bus.issue_rt      = 5'($urandom_range(1, 31));
            bus.issue_use_rs  = 1'b1;
            bus.issue_use_rt  = 1'b1;
            bus.issue_tuse_rs = 2'($urandom_range(0, 3));
            bus.issue_tuse_rt = 2'($urandom_range(0, 3));
            bus.issue_wr      = 1'b1;
            bus.issue_dst     = 5'($urandom_range(1, 31));
            bus.issue_tnew    = CNT_W'($urandom_range(0, 7));
            bus.issue_is_md   = 1'b1;
            bus.mdu_busy      = 1'b1;
            push_stall(1'b0);
            to_sample();
            e = expq.pop_front();
            vectors++;
            if (bus.stall !== e.stall) begin
                miscompares++;
                $display("FAIL reset_stall c%0d: stall=%b required %b", i, bus.stall, e.stall);
            end
            to_drive();
        end
        reset = 1'b0;
        idle();
        to_sample();
        vectors++;
        if (bus.busy_mask !== 32'h0 || bus.stall_count !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy_mask=%h stall_count=%0d required 0/0",
                     bus.busy_mask, bus.stall_count);
        end
        to_drive();
    endtask

    // lw $8 (Tnew=3), one cycle in E, then a Tuse=0 consumer: 2 stall cycles.
    task automatic test_load_use();
        exp_t e;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd8, 3'd3);
        to_drive();
        idle();
        to_drive();
        drive(1'b1, 5'd8, 1'b1, 2'd0, 1'b0, 5'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            push_stall(i < 2);
            to_sample();
            e = expq.pop_front();
            vectors++;
            if (bus.stall !== e.stall) begin
                miscompares++;
                $display("FAIL load_use c%0d: stall=%b required %b", i, bus.stall, e.stall);
            end
            to_drive();
        end
        idle();
        to_sample();
        vectors++;
        if (bus.stall_count !== 32'd2) begin
            miscompares++;
            $display("FAIL load_use_count: stall_count=%0d required 2", bus.stall_count);
        end
        to_drive();
    endtask

    task automatic test_alu();
        exp_t e;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd9, 3'd1);
        to_drive();
        idle();
        to_drive();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 3'd0);
        bus.issue_rt     = 5'd9;
        bus.issue_use_rt = 1'b1;
        push_stall(1'b0);
        to_sample();
        e = expq.pop_front();
        vectors++;
        if (bus.stall !== e.stall || bus.busy_mask[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_fwd: stall=%b mask9=%b required %b/0", bus.stall, bus.busy_mask[9], e.stall);
        end
        to_drive();
    endtask

    task automatic test_zero_tnew();
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd0, 3'd3);
                1: drive(1'b1, 5'd0, 1'b1, 2'd0, 1'b0, 5'd0, 3'd0);
                2: drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd5, 3'd0);
                default: drive(1'b1, 5'd5, 1'b1, 2'd0, 1'b0, 5'd0, 3'd0);
            endcase
            push_stall(1'b0);
            to_sample();
            e = expq.pop_front();
            vectors++;
            if (bus.stall !== e.stall || bus.busy_mask[0] !== 1'b0 || bus.busy_mask[5] !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_tnew c%0d: stall=%b mask0=%b mask5=%b required %b/0/0",
                         i, bus.stall, bus.busy_mask[0], bus.busy_mask[5], e.stall);
            end
            to_drive();
        end
    endtask

    task automatic test_waw();
        exp_t e;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd4, 3'd3);
        to_drive();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd4, 3'd1);
        to_drive();
        idle();
        to_sample();
        vectors++;
        if (bus.busy_mask[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_load: mask4=%b required 1", bus.busy_mask[4]);
        end
        to_drive();
        drive(1'b1, 5'd4, 1'b1, 2'd0, 1'b0, 5'd0, 3'd0);
        push_stall(1'b0);
        to_sample();
        e = expq.pop_front();
        vectors++;
        if (bus.stall !== e.stall || bus.busy_mask[4] !== 1'b0) begin
            miscompares++;
            $display("FAIL waw_read: stall=%b mask4=%b required %b/0", bus.stall, bus.busy_mask[4], e.stall);
        end
        to_drive();
    endtask

    // Consumer directly behind its producer, rt path with Tuse=2, then a self-dependent writer.
    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd10, 3'd4);
        to_drive();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b0, 5'd0, 3'd0);
        bus.issue_rt      = 5'd10;
        bus.issue_use_rt  = 1'b1;
        bus.issue_tuse_rt = 2'd2;
        for (int i = 0; i < 3; i++) begin
            push_stall(i < 2);
            to_sample();
            e = expq.pop_front();
            vectors++;
            if (bus.stall !== e.stall) begin
                miscompares++;
                $display("FAIL b2b_rt c%0d: stall=%b required %b", i, bus.stall, e.stall);
            end
            to_drive();
        end
        drive(1'b1, 5'd12, 1'b1, 2'd0, 1'b1, 5'd12, 3'd3);
        push_stall(1'b0);
        to_sample();
        e = expq.pop_front();
        vectors++;
        if (bus.stall !== e.stall || bus.stall_count !== 32'd2) begin
            miscompares++;
            $display("FAIL b2b_selfdep: stall=%b stall_count=%0d required %b/2", bus.stall, bus.stall_count, e.stall);
        end
        to_drive();
        idle();
        to_sample();
        vectors++;
        if (bus.busy_mask[12] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_selfdep_load: mask12=%b required 1", bus.busy_mask[12]);
        end
        to_drive();
    endtask

    task automatic test_mdu_reset();
        exp_t e;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 2'd0, 1'b1, 5'd7, 3'd7);
        to_drive();
        for (int i = 0; i < 6; i++) begin
            idle();
            reset           = (i == 2);
            bus.issue_valid = 1'b1;
            bus.issue_is_md = 1'b1;
            bus.mdu_busy    = (i < 5);
            push_stall(i != 2 && i < 5);
            to_sample();
            e = expq.pop_front();
            vectors++;
            if (bus.stall !== e.stall) begin
                miscompares++;
                $display("FAIL mdu c%0d: stall=%b required %b", i, bus.stall, e.stall);
            end
            if (i == 3) begin
                vectors++;
                if (bus.stall_count !== 32'd0 || bus.busy_mask !== 32'h0) begin
                    miscompares++;
                    $display("FAIL mdu_after_reset: stall_count=%0d busy_mask=%h required 0/0",
                             bus.stall_count, bus.busy_mask);
                end
            end
            if (i == 5) begin
                vectors++;
                if (bus.stall_count !== 32'd2) begin
                    miscompares++;
                    $display("FAIL mdu_count: stall_count=%0d required 2", bus.stall_count);
                end
            end
            to_drive();
        end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_random();
        exp_t e;
        int   mcnt [32];
        logic [PERF_W-1:0] mcount;
        logic [31:0] mmask;
        logic hs, ht, hm, s, acc;
        do_reset();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        mcount = '0;
        for (int i = 0; i < 400; i++) begin
            reset             = ($urandom_range(0, 59) == 0);
            bus.issue_valid   = ($urandom_range(0, 4) != 0);
            bus.issue_rs      = 5'($urandom_range(0, 7));
            bus.issue_rt      = 5'($urandom_range(0, 7));
            bus.issue_use_rs  = 1'($urandom_range(0, 1));
            bus.issue_use_rt  = 1'($urandom_range(0, 1));
            bus.issue_tuse_rs = 2'($urandom_range(0, 3));
            bus.issue_tuse_rt = 2'($urandom_range(0, 3));
            bus.issue_wr      = 1'($urandom_range(0, 1));
            bus.issue_dst     = 5'($urandom_range(0, 7));
            bus.issue_tnew    = CNT_W'($urandom_range(0, 7));
            bus.issue_is_md   = ($urandom_range(0, 3) == 0);
            bus.mdu_busy      = ($urandom_range(0, 2) == 0);
            hs = bus.issue_use_rs && bus.issue_rs != 0 && mcnt[bus.issue_rs] > int'(bus.issue_tuse_rs);
            ht = bus.issue_use_rt && bus.issue_rt != 0 && mcnt[bus.issue_rt] > int'(bus.issue_tuse_rt);
            hm = bus.issue_is_md && bus.mdu_busy;
            s  = bus.issue_valid && !reset && (hs || ht || hm);
            for (int r = 0; r < 32; r++) mmask[r] = (mcnt[r] != 0);
            e.stall = s;
            e.mask  = mmask;
            e.count = mcount;
            expq.push_back(e);
            to_sample();
            e = expq.pop_front();
            vectors++;
            if (bus.stall !== e.stall || bus.busy_mask !== e.mask || bus.stall_count !== e.count) begin
                miscompares++;
                $display("FAIL random c%0d: stall=%b mask=%h count=%0d required %b/%h/%0d",
                         i, bus.stall, bus.busy_mask, bus.stall_count, e.stall, e.mask, e.count);
            end
            acc = bus.issue_valid && !s;
            if (reset) begin
                for (int r = 0; r < 32; r++) mcnt[r] = 0;
                mcount = '0;
            end else begin
                for (int r = 0; r < 32; r++) if (mcnt[r] > 0) mcnt[r]--;
                if (acc && bus.issue_wr && bus.issue_dst != 0) mcnt[bus.issue_dst] = int'(bus.issue_tnew);
                if (s) mcount++;
            end
            to_drive();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_alu();
        test_zero_tnew();
        test_waw();
        test_back_to_back();
        test_mdu_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
